// File: rtl/frontend_ctrl_pkg.sv
// qu_common: shared types and defaults for the Qu core front end.
//
// Contents:
//   QU_PC_WIDTH      default width of PC/target buses
//   QU_FLUSH_CYCLES  default number of FLUSH cycles after a redirect
//   redirect_cause_t which source owns the redirect in progress
//   fe_state_t       front-end redirect sequencer states
//   drop_count()     number of br/jmp requests discarded in one cycle
package qu_common;

  localparam int unsigned QU_PC_WIDTH     = 32;
  localparam int unsigned QU_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_JUMP   = 2'd1,
    CAUSE_BRANCH = 2'd2,
    CAUSE_EXC    = 2'd3
  } redirect_cause_t;

  typedef enum logic [1:0] {
    FE_RUN,
    FE_REDIRECT,
    FE_FLUSH,
    FE_REFILL
  } fe_state_t;

  // In RUN the highest-priority br/jmp request (if no exception) is accepted;
  // every other br/jmp request seen in the cycle is thrown away.
  function automatic logic [1:0] drop_count(input logic in_run, input logic exc_req,
                                            input logic br_req, input logic jmp_req);
    logic [1:0] n;
    n = 2'(br_req) + 2'(jmp_req);
    if (in_run && !exc_req && (br_req || jmp_req)) begin
      n = n - 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/frontend_ctrl_if.sv
// frontend_ctrl_if: redirect-request and front-end control bundle.
//
// Request side (into the controller):
//   exc_req/exc_target, br_req/br_target, jmp_req/jmp_target, fifo_empty
// Front-end side (out of the controller):
//   fetch_redirect, pc_override, fifo_flush, id_stall, cause, busy
//   redirect_cnt, dropped_cnt  (only when QU_FRONTEND_STATS_EN is defined)
//
// Modports: slave = the controller, master = the surrounding core / bench.
interface frontend_ctrl_if #(
  parameter int unsigned PC_WIDTH = qu_common::QU_PC_WIDTH
);
  import qu_common::*;

  logic                exc_req;
  logic [PC_WIDTH-1:0] exc_target;
  logic                br_req;
  logic [PC_WIDTH-1:0] br_target;
  logic                jmp_req;
  logic [PC_WIDTH-1:0] jmp_target;
  logic                fifo_empty;

  logic                fetch_redirect;
  logic [PC_WIDTH-1:0] pc_override;
  logic                fifo_flush;
  logic                id_stall;
  redirect_cause_t     cause;
  logic                busy;

`ifdef QU_FRONTEND_STATS_EN
  logic [31:0]         redirect_cnt;
  logic [31:0]         dropped_cnt;
`endif

  modport slave (
    input  exc_req, exc_target, br_req, br_target, jmp_req, jmp_target, fifo_empty,
    output fetch_redirect, pc_override, fifo_flush, id_stall, cause, busy
`ifdef QU_FRONTEND_STATS_EN
    , redirect_cnt, dropped_cnt
`endif
  );

  modport master (
    output exc_req, exc_target, br_req, br_target, jmp_req, jmp_target, fifo_empty,
    input  fetch_redirect, pc_override, fifo_flush, id_stall, cause, busy
`ifdef QU_FRONTEND_STATS_EN
    , redirect_cnt, dropped_cnt
`endif
  );

endinterface

// File: rtl/frontend_ctrl_event_counter.sv
// event_counter: free-running wrapping event counter.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset, clears the count
//   step_i   amount added on each rising edge (0 = no event)
//   count_o  current count, wraps modulo 2**Width
module event_counter #(
  parameter int unsigned Width     = 32,
  parameter int unsigned StepWidth = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [StepWidth-1:0] step_i,
  output logic [Width-1:0]     count_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q + Width'(step_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/frontend_ctrl.sv
// frontend_ctrl: front-end redirect sequencer for the Qu core.
//
// Picks one redirect (exception > branch > jump), then pulses fetch_redirect,
// holds the IF/ID FIFO in flush for 1 + FLUSH_CYCLES cycles and stalls decode
// until the FIFO holds right-path instructions again. An exception arriving
// mid-sequence restarts it. All outputs come from registers only.
//
// Ports:
//   clk  core clock
//   rst  asynchronous active-low reset
//   bus  frontend_ctrl_if.slave: request inputs, fifo_empty, and the
//        fetch_redirect/pc_override/fifo_flush/id_stall/cause/busy outputs
//
// Build option: QU_FRONTEND_STATS_EN adds redirect_cnt and dropped_cnt.
module frontend_ctrl
  import qu_common::*;
#(
  parameter int unsigned PC_WIDTH     = QU_PC_WIDTH,
  parameter int unsigned FLUSH_CYCLES = QU_FLUSH_CYCLES
) (
  input logic           clk,
  input logic           rst,
  frontend_ctrl_if.slave bus
);

  localparam int unsigned CntWidth = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLoad = CntWidth'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("frontend_ctrl: FLUSH_CYCLES must be at least 1");
  end

  fe_state_t           state_d, state_q;
  logic [CntWidth-1:0] cnt_d, cnt_q;
  logic [PC_WIDTH-1:0] target_d, target_q;
  redirect_cause_t     cause_d, cause_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    cause_d  = cause_q;

    unique case (state_q)
      FE_RUN: begin
        if (bus.exc_req) begin
          target_d = bus.exc_target;
          cause_d  = CAUSE_EXC;
          state_d  = FE_REDIRECT;
        end else if (bus.br_req) begin
          target_d = bus.br_target;
          cause_d  = CAUSE_BRANCH;
          state_d  = FE_REDIRECT;
        end else if (bus.jmp_req) begin
          target_d = bus.jmp_target;
          cause_d  = CAUSE_JUMP;
          state_d  = FE_REDIRECT;
        end
      end
      FE_REDIRECT: begin
        cnt_d   = CntLoad;
        state_d = FE_FLUSH;
      end
      FE_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = FE_REFILL;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      FE_REFILL: begin
        if (!bus.fifo_empty) begin
          state_d = FE_RUN;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        state_d = FE_RUN;
      end
    endcase

    // An exception outranks every in-flight sequence step, including the
    // exits from FLUSH and REFILL; br/jmp outside RUN are wrong-path noise.
    if (state_q != FE_RUN && bus.exc_req) begin
      target_d = bus.exc_target;
      cause_d  = CAUSE_EXC;
      state_d  = FE_REDIRECT;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FE_RUN;
      cnt_q    <= '0;
      target_q <= '0;
      cause_q  <= CAUSE_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    bus.fetch_redirect = (state_q == FE_REDIRECT);
    bus.fifo_flush     = (state_q == FE_REDIRECT) || (state_q == FE_FLUSH);
    bus.id_stall       = (state_q != FE_RUN);
    bus.busy           = (state_q != FE_RUN);
    bus.pc_override    = target_q;
    bus.cause          = cause_q;
  end

`ifdef QU_FRONTEND_STATS_EN
  logic       redirect_entry;
  logic [1:0] drop_amt;

  always_comb begin
    // Every latch event, and only a latch event, heads for REDIRECT.
    redirect_entry = (state_d == FE_REDIRECT);
    drop_amt       = drop_count(state_q == FE_RUN, bus.exc_req, bus.br_req, bus.jmp_req);
  end

  event_counter #(
    .Width     (32),
    .StepWidth (1)
  ) u_redirect_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .step_i  (redirect_entry),
    .count_o (bus.redirect_cnt)
  );

  event_counter #(
    .Width     (32),
    .StepWidth (2)
  ) u_dropped_cnt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .step_i  (drop_amt),
    .count_o (bus.dropped_cnt)
  );
`endif

endmodule

// File: tb/tb_frontend_ctrl.sv
// Self-checking bench for frontend_ctrl (FLUSH_CYCLES = 2). A sequence-age
// model predicts every output each cycle; directed scenarios add hand-computed
// expectations, followed by a randomized run.
module tb_frontend_ctrl;
  import qu_common::*;

  localparam int unsigned FC = 2;
  localparam int unsigned PW = QU_PC_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  frontend_ctrl_if #(.PC_WIDTH(PW)) bus ();

  frontend_ctrl #(
    .PC_WIDTH     (PW),
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Model: a sequence is either inactive or 'age' cycles past its redirect.
  // age 0 = redirect cycle, 1..FC = flushing, >FC = waiting for refill.
  bit          m_active;
  int unsigned m_age;
  logic [PW-1:0] m_tgt;
  logic [1:0]  m_cause;
`ifdef QU_FRONTEND_STATS_EN
  logic [31:0] m_redir;
  logic [31:0] m_drop;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_age    = 0;
    m_tgt    = '0;
    m_cause  = 2'd0;
`ifdef QU_FRONTEND_STATS_EN
    m_redir  = '0;
    m_drop   = '0;
`endif
  endtask

  task automatic model_step();
    logic [1:0] nd;
    logic       any;
    nd  = 2'(bus.br_req) + 2'(bus.jmp_req);
    any = bus.exc_req | bus.br_req | bus.jmp_req;
    if (!m_active) begin
      if (bus.exc_req) begin
        m_tgt = bus.exc_target; m_cause = 2'd3;
      end else if (bus.br_req) begin
        m_tgt = bus.br_target; m_cause = 2'd2; nd = nd - 2'd1;
      end else if (bus.jmp_req) begin
        m_tgt = bus.jmp_target; m_cause = 2'd1; nd = nd - 2'd1;
      end
      if (any) begin
        m_active = 1'b1;
        m_age    = 0;
`ifdef QU_FRONTEND_STATS_EN
        m_redir  = m_redir + 32'd1;
`endif
      end
    end else if (bus.exc_req) begin
      m_tgt   = bus.exc_target;
      m_cause = 2'd3;
      m_age   = 0;
`ifdef QU_FRONTEND_STATS_EN
      m_redir = m_redir + 32'd1;
`endif
    end else if (m_age <= FC) begin
      m_age++;
    end else if (!bus.fifo_empty) begin
      m_active = 1'b0;
      m_cause  = 2'd0;
    end
`ifdef QU_FRONTEND_STATS_EN
    m_drop = m_drop + 32'(nd);
`endif
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_fetch_redirect", 64'(bus.fetch_redirect), 64'(m_active && (m_age == 0)));
      chk("m_fifo_flush", 64'(bus.fifo_flush), 64'(m_active && (m_age <= FC)));
      chk("m_id_stall", 64'(bus.id_stall), 64'(m_active));
      chk("m_busy", 64'(bus.busy), 64'(m_active));
      chk("m_pc_override", 64'(bus.pc_override), 64'(m_tgt));
      chk("m_cause", 64'(bus.cause), 64'(m_cause));
`ifdef QU_FRONTEND_STATS_EN
      chk("m_redirect_cnt", 64'(bus.redirect_cnt), 64'(m_redir));
      chk("m_dropped_cnt", 64'(bus.dropped_cnt), 64'(m_drop));
`endif
    end
  end

  task automatic drive(input logic exc, input logic [PW-1:0] et, input logic br,
                       input logic [PW-1:0] bt, input logic jmp, input logic [PW-1:0] jt,
                       input logic empty);
    bus.exc_req    = exc;
    bus.exc_target = et;
    bus.br_req     = br;
    bus.br_target  = bt;
    bus.jmp_req    = jmp;
    bus.jmp_target = jt;
    bus.fifo_empty = empty;
  endtask

  task automatic idle(input logic empty);
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, empty);
  endtask

  // One clock: model follows the edge using the inputs present at it.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    #1;
  endtask

  initial begin
    int c_ff;
    int c_st;

    idle(1'b0);
    model_reset();
    cmp_en = 1'b1;
    cyc();
    cyc();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_pc", 64'(bus.pc_override), 64'd0);
    chk("rst_cause", 64'(bus.cause), 64'd0);
    rst = 1'b1;
    cyc();
    cyc();
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_redirect", 64'(bus.fetch_redirect), 64'd0);

    // Jump to 0x100
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h100, 1'b0);
    cyc();
    idle(1'b0);
    chk("jmp_pulse", 64'(bus.fetch_redirect), 64'd1);
    chk("jmp_pc", 64'(bus.pc_override), 64'h100);
    chk("jmp_cause", 64'(bus.cause), 64'(CAUSE_JUMP));
    c_ff = 0;
    c_st = 0;
    for (int i = 0; i < 8; i++) begin
      c_ff += int'(bus.fifo_flush);
      c_st += int'(bus.id_stall);
      cyc();
    end
    chk("jmp_flush_len", 64'(c_ff), 64'd3);
    chk("jmp_stall_len", 64'(c_st), 64'd4);
    chk("jmp_busy_done", 64'(bus.busy), 64'd0);
    chk("jmp_pc_hold", 64'(bus.pc_override), 64'h100);
    chk("jmp_cause_none", 64'(bus.cause), 64'd0);

    // Priority: all three at once
    drive(1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
    cyc();
    idle(1'b0);
    chk("prio_pc", 64'(bus.pc_override), 64'h80);
    chk("prio_cause", 64'(bus.cause), 64'(CAUSE_EXC));
`ifdef QU_FRONTEND_STATS_EN
    chk("prio_dropped", 64'(bus.dropped_cnt), 64'd2);
    chk("prio_redirects", 64'(bus.redirect_cnt), 64'd2);
`endif
    for (int i = 0; i < 4; i++) cyc();
    chk("prio_busy_done", 64'(bus.busy), 64'd0);

    // Preemption in the second FLUSH cycle
    drive(1'b0, '0, 1'b1, 32'h200, 1'b0, '0, 1'b0);
    cyc();
    idle(1'b0);
    chk("pre_br_pc", 64'(bus.pc_override), 64'h200);
    cyc();
    cyc();
    chk("pre_in_flush", 64'(bus.fifo_flush), 64'd1);
    drive(1'b1, 32'h80, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc();
    idle(1'b0);
    chk("pre_pulse", 64'(bus.fetch_redirect), 64'd1);
    chk("pre_pc", 64'(bus.pc_override), 64'h80);
    chk("pre_cause", 64'(bus.cause), 64'(CAUSE_EXC));
`ifdef QU_FRONTEND_STATS_EN
    chk("pre_redirects", 64'(bus.redirect_cnt), 64'd4);
`endif
    c_ff = 0;
    for (int i = 0; i < 6; i++) begin
      c_ff += int'(bus.fifo_flush);
      cyc();
    end
    chk("pre_flush_len", 64'(c_ff), 64'd3);
    chk("pre_busy_done", 64'(bus.busy), 64'd0);

    // Refill wait: FIFO stays empty for 5 REFILL cycles
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h300, 1'b1);
    cyc();
    idle(1'b1);
    cyc();
    cyc();
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("refill_stall", 64'(bus.id_stall), 64'd1);
      chk("refill_noflush", 64'(bus.fifo_flush), 64'd0);
      cyc();
    end
    idle(1'b0);
    chk("refill_still_busy", 64'(bus.busy), 64'd1);
    cyc();
    chk("refill_exit", 64'(bus.busy), 64'd0);
    chk("refill_pc", 64'(bus.pc_override), 64'h300);

    // Wrong-path branch during FLUSH
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h40, 1'b0);
    cyc();
    idle(1'b0);
    cyc();
    drive(1'b0, '0, 1'b1, 32'h999, 1'b0, '0, 1'b0);
    cyc();
    idle(1'b0);
    chk("wp_no_pulse", 64'(bus.fetch_redirect), 64'd0);
    chk("wp_pc", 64'(bus.pc_override), 64'h40);
    chk("wp_cause", 64'(bus.cause), 64'(CAUSE_JUMP));
`ifdef QU_FRONTEND_STATS_EN
    chk("wp_dropped", 64'(bus.dropped_cnt), 64'd3);
    chk("wp_redirects", 64'(bus.redirect_cnt), 64'd6);
`endif
    cyc();
    cyc();
    chk("wp_busy_done", 64'(bus.busy), 64'd0);

    // Asynchronous reset in the middle of FLUSH
    drive(1'b0, '0, 1'b0, '0, 1'b1, 32'h123, 1'b0);
    cyc();
    idle(1'b0);
    cyc();
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("arst_redirect", 64'(bus.fetch_redirect), 64'd0);
    chk("arst_flush", 64'(bus.fifo_flush), 64'd0);
    chk("arst_stall", 64'(bus.id_stall), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_pc", 64'(bus.pc_override), 64'd0);
    chk("arst_cause", 64'(bus.cause), 64'd0);
    drive(1'b1, 32'h55, 1'b0, '0, 1'b0, '0, 1'b0);
    cyc();
    cyc();
    idle(1'b0);
    rst = 1'b1;
    cyc();
    cyc();
    chk("arst_release_busy", 64'(bus.busy), 64'd0);
    chk("arst_release_pc", 64'(bus.pc_override), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 11) == 0, $urandom(),
            $urandom_range(0, 5) == 0, $urandom(),
            $urandom_range(0, 5) == 0, $urandom(),
            $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        model_reset();
        cyc();
        rst = 1'b1;
      end else begin
        cyc();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
